// File: rtl/matrix_result_reader.sv
// Drains the DIMxDIM result RAM into a valid/ready stream tagged with row/col/last, 1 element/cycle.
// Define MATRIX_RESULT_READER_TRANSPOSE_EN for column-major issue order (tags still give true row/col).
module matrix_result_reader #(
   parameter int WIDTH  = 19,
   parameter int DIM    = 8,
   parameter int ADDR_W = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     ram_rd_en,
   output logic [ADDR_W-1:0]        ram_addr,
   input  logic signed [WIDTH-1:0]  ram_rdata,
   output logic signed [WIDTH-1:0]  out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DIM)-1:0]   out_row,
   output logic [$clog2(DIM)-1:0]   out_col,
   output logic                     out_last
);
   localparam int RC_W  = $clog2(DIM);
   localparam int NUM   = DIM * DIM;
   localparam int CNT_W = ADDR_W + 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;

   typedef struct packed {
      logic [WIDTH-1:0] dat;
      logic [RC_W-1:0]  row;
      logic [RC_W-1:0]  col;
      logic             last;
   } entry_t;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic             infl_q, infl_d;
   logic [RC_W-1:0]  infl_row_q, infl_row_d;
   logic [RC_W-1:0]  infl_col_q, infl_col_d;
   logic             infl_last_q, infl_last_d;
   logic [1:0]       occ_q, occ_d;
   entry_t           head_q, head_d;
   entry_t           skid_q, skid_d;

   logic             push, pop;
   logic [RC_W-1:0]  rd_row, rd_col;
   entry_t           new_ent;

`ifdef MATRIX_RESULT_READER_TRANSPOSE_EN
   assign rd_row = RC_W'(rd_cnt_q % DIM);
   assign rd_col = RC_W'(rd_cnt_q / DIM);
`else
   assign rd_row = RC_W'(rd_cnt_q / DIM);
   assign rd_col = RC_W'(rd_cnt_q % DIM);
`endif

   assign ram_addr  = ADDR_W'(rd_row * DIM + rd_col);
   assign out_valid = (occ_q != 2'd0);
   assign out_data  = head_q.dat;
   assign out_row   = head_q.row;
   assign out_col   = head_q.col;
   assign out_last  = head_q.last;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == FINISH);
   assign push      = infl_q;
   assign pop       = out_valid & out_ready;

   // Room check counts the pop happening this cycle, so a full FIFO being drained still issues.
   assign ram_rd_en = (state_q == RUN) && (rd_cnt_q < CNT_W'(NUM)) &&
                      (({1'b0, occ_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop}));

   always_comb begin
      new_ent.dat  = ram_rdata;
      new_ent.row  = infl_row_q;
      new_ent.col  = infl_col_q;
      new_ent.last = infl_last_q;

      state_d     = state_q;
      rd_cnt_d    = rd_cnt_q;
      infl_d      = ram_rd_en;
      infl_row_d  = rd_row;
      infl_col_d  = rd_col;
      infl_last_d = (rd_cnt_q == CNT_W'(NUM - 1));
      occ_d       = occ_q;
      head_d      = head_q;
      skid_d      = skid_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               rd_cnt_d = '0;
            end
         end
         RUN: begin
            if (ram_rd_en)
               rd_cnt_d = rd_cnt_q + CNT_W'(1);
            if (pop && head_q.last)
               state_d = FINISH;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) head_d = new_ent;
            else               skid_d = new_ent;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            head_d = skid_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd2) begin
               head_d = skid_q;
               skid_d = new_ent;
            end else begin
               head_d = new_ent;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         rd_cnt_q    <= '0;
         infl_q      <= 1'b0;
         infl_row_q  <= '0;
         infl_col_q  <= '0;
         infl_last_q <= 1'b0;
         occ_q       <= 2'd0;
         head_q      <= '0;
         skid_q      <= '0;
      end else begin
         state_q     <= state_d;
         rd_cnt_q    <= rd_cnt_d;
         infl_q      <= infl_d;
         infl_row_q  <= infl_row_d;
         infl_col_q  <= infl_col_d;
         infl_last_q <= infl_last_d;
         occ_q       <= occ_d;
         head_q      <= head_d;
         skid_q      <= skid_d;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && !pop && occ_q == 2'd2));

endmodule

// File: doc/matrix_result_reader.md
Name: matrix_result_reader

Overview:
- Drain engine on the read side of the 8x8 result matrix RAM that the MAC array writes.
- On a start pulse it reads all 64 signed 19-bit results, one element per cycle, through a 1-cycle-latency synchronous read port.
- It streams the results out on a valid/ready interface, tagged with row, column and last.
- Sustains 1 element/cycle under continuous ready; tolerates arbitrary backpressure without loss or duplication.

Parameters:
- WIDTH, 19, signed element width (matches MAC accumulator output)
- DIM, 8, matrix dimension; element count = DIM*DIM
- ADDR_W, 6, RAM address width; must equal clog2(DIM*DIM)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin one drain; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the last element is accepted
- done  out  1  one-cycle pulse the cycle after the last handshake
- ram_rd_en  out  1  read strobe to result RAM
- ram_addr  out  ADDR_W  read address
- ram_rdata  in  WIDTH  signed read data, valid exactly 1 cycle after ram_rd_en
- out_data  out  WIDTH  signed element
- out_valid  out  1  out_data/tags valid
- out_ready  in  1  sink accepts when out_valid and out_ready are both high
- out_row  out  clog2(DIM)  row index of out_data
- out_col  out  clog2(DIM)  column index of out_data
- out_last  out  1  high with the 64th element

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all counters=0, buffers empty. busy, done, ram_rd_en, out_valid and out_last are 0; ram_addr, out_data, out_row and out_col are 0.
- FSM states: IDLE, RUN, FINISH.
  - IDLE->RUN: on start=1.
  - RUN->FINISH: on the handshake of the element with out_last=1.
  - FINISH->IDLE: unconditional after 1 cycle; done=1 in FINISH.
- start is ignored in RUN and FINISH; there is no queued restart.
- Issue counter rd_cnt (0..64) generates addresses in row-major order: ram_addr = rd_cnt, so row = rd_cnt/DIM and col = rd_cnt%DIM.
- Buffering: a 2-entry FIFO (output register plus skid entry) holds data with its row/col/last tags.
  - occ = entries held; infl = reads issued whose data has not yet returned (0 or 1).
  - pop = out_valid & out_ready.
  - Issue rule: ram_rd_en = (state==RUN) & (rd_cnt<64) & (occ + infl - pop < 2). This is combinational on out_ready.
- Returning ram_rdata is written into the FIFO the cycle after issue. The FIFO never overflows; overflow is an assertion failure.
- out_valid = (occ != 0). out_data and the tags come from the head entry and stay stable while out_valid=1 and out_ready=0.
- Latency: start accepted at cycle T; first read issued at T+1; out_valid first high at T+3.
  - With out_ready held at 1, one element per cycle.
  - Last handshake at T+66; done pulses at T+67.
- Simultaneous push and pop in the same cycle are legal; occ is unchanged.
- Elements are passed through unmodified. There is no sign extension or arithmetic on data; all-ones (-1) and -2^18 pass intact.
- Reset asserted mid-drain: immediate return to reset values. Pending in-flight read data is discarded, and a subsequent start restarts at address 0.
- The result RAM contents must not change while busy=1; that is the caller's responsibility and is not checked.

Optional Feature:
- Macro: MATRIX_RESULT_READER_TRANSPOSE_EN
- Defined: issue order is column-major, ram_addr = (rd_cnt%DIM)*DIM + rd_cnt/DIM.
  - out_row and out_col still report the true row/column of each element, so the stream order is (0,0),(1,0),...,(7,0),(0,1),...
  - out_last is on (7,7).
  - Timing is identical.
- Undefined: row-major only, as above.

Test Plan:
- Continuous drain: RAM[i] = i-32, out_ready=1, start pulse at T.
  - Expect out_data -32..31 on cycles T+3..T+66 with row/col = i/8, i%8.
  - out_last only on 31; done=1 at T+67 only; busy=0 after.
- Backpressure: same RAM, out_ready pattern 1,0,0,1 repeating.
  - Expect the same 64-value ordered sequence with no gaps or duplicates.
  - out_data stable while stalled; ram_rd_en never issued when occ+infl-pop would reach 2.
- Extremes: RAM[0] = -262144, RAM[1] = 262143, RAM[63] = -1.
  - Expect out_data bit-exact: 19'h40000, 19'h3FFFF, 19'h7FFFF.
- Start while busy: second start pulse at T+10.
  - Expect it ignored: exactly 64 elements and one done pulse.
- Reset mid-stream: drop rst at element 20 with out_ready=0.
  - Expect out_valid=0 and busy=0 asynchronously.
  - After rst=1 and a new start, the stream restarts at element 0 with value -32.
- With MATRIX_RESULT_READER_TRANSPOSE_EN and RAM[i] = i:
  - Expect out_data 0,8,16,...,56,1,9,...,63 with the matching row/col tags; out_last with 63.
